// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_regs_pkg;

  localparam int         NUM_REGS         = 4;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output only follows
// the pin after FILTER_LEN consecutive samples that disagree with it.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      filtered <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == filtered) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filtered <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing four 8-bit registers, also accessible over Avalon-MM.
// A write sets a pointer byte then data; reads stream from the pointer.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       busy,
  output logic       wr_strobe,
  output logic [1:0] wr_index
);

  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic       byte_done, ack_end;

  i2c_state_t state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] tx_q;
  logic [1:0] ptr_q;
  logic       ack_on_q;
  logic       rw_q;
  logic [7:0] regs_q [NUM_REGS];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .reset_n(reset_n), .raw(scl_in), .filtered(scl_f)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .reset_n(reset_n), .raw(sda_in), .filtered(sda_f)
  );

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_in   = {shift_q, sda_f};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  // ack_on_q distinguishes the fall that opens an ACK slot from the one closing it
  assign ack_end   = scl_fall && ack_on_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR:      if (byte_done) state_d = (byte_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (ack_end)   state_d = rw_q ? ST_RDATA : ST_PTR;
        ST_PTR:       if (byte_done) state_d = ST_PTR_ACK;
        ST_PTR_ACK:   if (ack_end)   state_d = ST_WDATA;
        ST_WDATA:     if (byte_done) state_d = ST_WDATA_ACK;
        ST_WDATA_ACK: if (ack_end)   state_d = ST_WDATA;
        ST_RDATA:     if (byte_done) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: if (scl_rise)  state_d = sda_f ? ST_IGNORE : ST_RDATA;
        default:      state_d = state_q;
      endcase
    end
  end

  // NOTE: the register file is only four bytes and must read as zero after
  // reset, so it is reset like any other flop rather than left as a RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      ack_on_q  <= 1'b0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      readdata  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      wr_strobe <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt_q <= '0;
        ack_on_q  <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift_q   <= byte_in[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
              if (state_q == ST_ADDR) rw_q <= byte_in[0];
              if (state_q == ST_PTR)  ptr_q <= byte_in[1:0];
              if (state_q == ST_WDATA) begin
                regs_q[ptr_q] <= byte_in;
                wr_strobe     <= 1'b1;
                wr_index      <= ptr_q;
                ptr_q         <= ptr_q + 2'd1;
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              ack_on_q <= ~ack_on_q;
              if (!ack_on_q) begin
                sda_oe <= 1'b1;
              end else if (state_q == ST_ADDR_ACK && rw_q) begin
                tx_q   <= {regs_q[ptr_q][6:0], 1'b0};
                sda_oe <= ~regs_q[ptr_q][7];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) bit_cnt_q <= bit_cnt_q + 3'd1;
            // a fall with no bits counted follows a master ACK: fetch the next byte
            if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                tx_q   <= {regs_q[ptr_q][6:0], 1'b0};
                sda_oe <= ~regs_q[ptr_q][7];
              end else begin
                tx_q   <= {tx_q[6:0], 1'b0};
                sda_oe <= ~tx_q[7];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise && !sda_f) ptr_q <= ptr_q + 2'd1;
          end
          default: ;
        endcase
      end
      // Avalon write follows the I2C write so it wins a same-index collision
      if (chipselect && !write_n) regs_q[address] <= writedata;
      readdata <= regs_q[address];
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: Avalon vector table plus bit-banged I2C master sequences.
module tb_i2c_target_regs;

  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m_scl, m_sda;
  wire        sda_bus;
  logic       sda_oe;
  logic [1:0] address;
  logic       chipselect, write_n;
  logic [7:0] writedata, readdata;
  logic       busy, wr_strobe;
  logic [1:0] wr_index;

  int checks = 0;
  int errors = 0;
  int oe_count = 0;
  logic [1:0] strobe_q[$];

  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_regs dut (
    .clk(clk), .reset_n(reset_n), .scl_in(m_scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .busy(busy), .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sda_oe) oe_count++;
    if (wr_strobe) strobe_q.push_back(wr_index);
  end

  typedef struct {
    logic       cs;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic wr_bit(input logic b, input logic glitch, input logic collide);
    m_sda = b; tick(Q);
    m_scl = 1'b1;
    if (collide) begin
      // land the Avalon write on the clk that commits the I2C byte
      tick(5);
      chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 8'h77;
      tick(1);
      check("collide_strobe_aligned", wr_strobe, 1);
      chipselect = 1'b0; write_n = 1'b1;
      tick(Q - 6);
    end else if (glitch) begin
      tick(Q / 2);
      m_sda = 1'b0; tick(1);
      m_sda = 1'b1; tick(Q / 2 - 1);
    end else begin
      tick(Q);
    end
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int glitch_at, input logic collide,
                         output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i], glitch_at == i, collide && i == 0);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q / 2);
    ack = ~sda_bus; tick(Q / 2);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic ack);
    logic [7:0] v;
    v = '0;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(Q);
      m_scl = 1'b1; tick(Q / 2);
      v = {v[6:0], sda_bus}; tick(Q / 2);
      m_scl = 1'b0;
    end
    tick(Q);
    m_sda = ~ack; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_scl = 1'b0; tick(Q / 2);
    m_sda = 1'b1; tick(Q / 2);
    d = v;
  endtask

  task automatic avalon_read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    chipselect = 1'b0; write_n = 1'b1; address = a;
    tick(1);
    check(name, readdata, exp);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s0, oe0;

    vecs[0] = '{1'b1, 1'b0, 2'd0, 8'h11, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 8'h22, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 8'h33, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 8'h44, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h11};
    vecs[5] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h44};
    vecs[6] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h22};
    vecs[7] = '{1'b0, 1'b0, 2'd2, 8'hFF, 8'h33};
    vecs[8] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h33};
    vecs[9] = '{1'b1, 1'b1, 2'd1, 8'h00, 8'h22};

    reset_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 8'h00;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_readdata", readdata, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_index", wr_index, 0);
    reset_n = 1'b1;
    tick(10);

    // Avalon register vectors (also preload 11,22,33,44)
    for (int i = 0; i < 10; i++) begin
      chipselect = vecs[i].cs; write_n = vecs[i].wr_n;
      address = vecs[i].addr; writedata = vecs[i].wdata;
      tick(1);
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
    end
    chipselect = 1'b0; write_n = 1'b1;

    // pointer 3, repeated start, read with wrap
    i2c_start();
    wr_byte(8'hA0, -1, 1'b0, ack); check("rd_addr_w_ack", ack, 1);
    wr_byte(8'h03, -1, 1'b0, ack); check("rd_ptr_ack", ack, 1);
    i2c_start();
    wr_byte(8'hA1, -1, 1'b0, ack); check("rd_addr_r_ack", ack, 1);
    rd_byte(rd, 1'b1); check("rd_byte0", rd, 8'h44);
    rd_byte(rd, 1'b1); check("rd_byte1_wrap", rd, 8'h11);
    rd_byte(rd, 1'b0); check("rd_byte2", rd, 8'h22);
    i2c_stop();
    check("rd_busy_after_stop", busy, 0);

    // write pointer 1 then two data bytes
    s0 = strobe_q.size();
    i2c_start();
    wr_byte(8'hA0, -1, 1'b0, ack); check("wr_addr_ack", ack, 1);
    wr_byte(8'h01, -1, 1'b0, ack); check("wr_ptr_ack", ack, 1);
    wr_byte(8'h5A, -1, 1'b0, ack); check("wr_d0_ack", ack, 1);
    wr_byte(8'h3C, -1, 1'b0, ack); check("wr_d1_ack", ack, 1);
    i2c_stop();
    check("wr_strobe_count", strobe_q.size() - s0, 2);
    if (strobe_q.size() - s0 == 2) begin
      check("wr_index_first", strobe_q[s0], 1);
      check("wr_index_second", strobe_q[s0 + 1], 2);
    end
    avalon_read_check("wr_reg1", 2'd1, 8'h5A);
    avalon_read_check("wr_reg2", 2'd2, 8'h3C);

    // address mismatch: never drive SDA, busy until STOP
    oe0 = oe_count;
    i2c_start();
    wr_byte(8'hA2, -1, 1'b0, ack); check("nomatch_ack", ack, 0);
    wr_byte(8'h55, -1, 1'b0, ack); check("nomatch_data_ack", ack, 0);
    check("nomatch_busy", busy, 1);
    i2c_stop();
    check("nomatch_busy_after_stop", busy, 0);
    check("nomatch_oe_cycles", oe_count - oe0, 0);

    // 1-clk SDA glitch on an idle bus is not a START
    m_sda = 1'b0; tick(1);
    m_sda = 1'b1; tick(Q);
    check("glitch_idle_busy", busy, 0);

    // glitch inside a pointer byte, then a colliding data write
    i2c_start();
    wr_byte(8'hA0, -1, 1'b0, ack); check("glitch_addr_ack", ack, 1);
    wr_byte(8'h02, 1, 1'b0, ack);  check("glitch_ptr_ack", ack, 1);
    wr_byte(8'h99, -1, 1'b1, ack); check("collide_data_ack", ack, 1);
    i2c_stop();
    check("collide_wr_index", wr_index, 2);
    avalon_read_check("collide_park", 2'd0, 8'h11);
    avalon_read_check("collide_reg2", 2'd2, 8'h77);

    // reset while the target drives read bit 0 (reg0=0x11, MSB 0)
    i2c_start();
    wr_byte(8'hA0, -1, 1'b0, ack); check("rst_mid_addr_ack", ack, 1);
    wr_byte(8'h00, -1, 1'b0, ack); check("rst_mid_ptr_ack", ack, 1);
    i2c_start();
    wr_byte(8'hA1, -1, 1'b0, ack); check("rst_mid_addr_r_ack", ack, 1);
    check("rst_mid_driving", sda_oe, 1);
    #2 reset_n = 1'b0;
    #1 check("rst_mid_async_release", sda_oe, 0);
    tick(2);
    reset_n = 1'b1;
    tick(Q);
    oe0 = oe_count;
    for (int i = 0; i < 9; i++) wr_bit(1'b0, 1'b0, 1'b0);
    check("rst_mid_busy_idle", busy, 0);
    check("rst_mid_no_drive", oe_count - oe0, 0);
    i2c_start();
    wr_byte(8'hA0, -1, 1'b0, ack); check("rst_mid_restart_ack", ack, 1);
    i2c_stop();
    check("rst_mid_final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
